prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter NUM_WORDS, default 64, meaning the number of 16-bit instruction words per load (range 1..64).
REQ-002 The block SHALL have parameter HI_FIRST, default 1, meaning high byte received first when 1 and low byte first when 0.
REQ-003 Port clka  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  begin a load session; sampled only in IDLE or DONE.
REQ-006 Port byte_valid  input  1  source has a byte on byte_data.
REQ-007 Port byte_data  input  8  incoming program byte.
REQ-008 Port byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 Port load  output  16  assembled instruction word to instruction memory.
REQ-010 Port we_ins  output  1  one-cycle instruction-memory write strobe.
REQ-011 Port wr_addr  output  6  word address of the current write.
REQ-012 Port cpu_reset  output  1  high holds the processor in reset.
REQ-013 Port busy  output  1  load session in progress.
REQ-014 Port done  output  1  session completed.
REQ-015 Port csum_err  output  1  checksum mismatch flag.

Function
REQ-016 The FSM SHALL have states IDLE, BYTE0, BYTE1, WRITE, CSUM, DONE.
REQ-017 IDLE or DONE with start=1 SHALL go to BYTE0 next cycle, clearing wr_addr, done, csum_err and the running sum, and setting cpu_reset=1.
REQ-018 A byte SHALL transfer only on a cycle with byte_valid=1 and byte_ready=1.
REQ-019 byte_ready SHALL be 1 exactly in BYTE0, BYTE1 and CSUM, and 0 in all other states.
REQ-020 With HI_FIRST=1, the BYTE0 byte SHALL go to load[15:8] and the BYTE1 byte to load[7:0]; with HI_FIRST=0 the mapping SHALL be swapped.
REQ-021 A transfer in BYTE0 SHALL move the FSM to BYTE1, and a transfer in BYTE1 SHALL move it to WRITE; with no transfer the FSM SHALL stay put for unlimited wait cycles.
REQ-022 In WRITE, we_ins SHALL be 1 for exactly one cycle, with load and wr_addr stable that cycle.
REQ-023 we_ins SHALL be 0 in every other state.
REQ-024 After WRITE, wr_addr SHALL increment modulo 64.
REQ-025 After WRITE, the FSM SHALL go to BYTE0 if fewer than NUM_WORDS words have been written, otherwise to CSUM (macro defined) or DONE.
REQ-026 Throughput SHALL be one word per 3 cycles minimum with byte_valid held high.
REQ-027 The last write SHALL be at wr_addr=NUM_WORDS-1.
REQ-028 With NUM_WORDS=64, wr_addr SHALL wrap to 0 on entry to DONE.
REQ-029 In DONE: done=1, busy=0, cpu_reset=0, and load SHALL hold its last value.
REQ-030 busy SHALL be 1 in BYTE0, BYTE1, WRITE and CSUM.
REQ-031 start asserted while busy=1 SHALL be ignored.
REQ-032 start held high in DONE SHALL restart the session, reasserting cpu_reset the next cycle.
REQ-033 byte_valid while byte_ready=0 SHALL be ignored and SHALL not be consumed.

Reset
REQ-034 While reset=0, the FSM SHALL be forced to IDLE immediately, independent of clka.
REQ-035 While reset=0: load=16'h0000, wr_addr=0, we_ins=0, byte_ready=0, busy=0, done=0, csum_err=0, running sum=0.
REQ-036 While reset=0, cpu_reset SHALL be 1, and it SHALL remain 1 in IDLE until a session reaches DONE.
REQ-037 Reset asserted mid-session SHALL abandon the session with no further we_ins; words already written stay as written.

Configuration
REQ-038 The block SHALL support macro PROG_LOADER_CHECKSUM_EN.
REQ-039 When PROG_LOADER_CHECKSUM_EN is defined, every accepted program byte SHALL be added to an 8-bit running sum modulo 256.
REQ-040 When PROG_LOADER_CHECKSUM_EN is defined, CSUM SHALL accept one byte and set csum_err=1 if (running sum + byte) mod 256 != 0, then go to DONE.
REQ-041 When PROG_LOADER_CHECKSUM_EN is defined and csum_err=1, cpu_reset SHALL stay 1 in DONE.
REQ-042 When PROG_LOADER_CHECKSUM_EN is undefined, the CSUM state and sum register SHALL be absent, csum_err SHALL be constant 0, and the FSM SHALL go WRITE to DONE directly.

Verification
REQ-043 NUM_WORDS=2, HI_FIRST=1, start, then bytes 12,34,AB,CD with valid held -> we_ins at wr_addr 0 with load=1234, at wr_addr 1 with load=ABCD, then done=1 and cpu_reset=0.
REQ-044 HI_FIRST=0, NUM_WORDS=1, bytes 34,12 -> one write at wr_addr 0 with load=1234.
REQ-045 byte_valid toggled randomly, NUM_WORDS=64 -> exactly 64 we_ins pulses, addresses 0..63 in order, wr_addr=0 in DONE.
REQ-046 Reset pulled low after the 3rd word is written -> outputs at reset values immediately, no 4th we_ins, and a restart begins at wr_addr 0.
REQ-047 Macro defined, NUM_WORDS=1, bytes 01,02, checksum FD -> csum_err=0 and cpu_reset=0; checksum FE -> csum_err=1 and cpu_reset=1.
REQ-048 start pulsed during BYTE1 -> no effect on state, wr_addr or count.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream source and instruction-memory write port of prog_loader.
// slave = loader side, master = byte source / memory side.
interface prog_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [15:0] load;
    logic        we_ins;
    logic [5:0]  wr_addr;

    modport slave  (input  byte_valid, byte_data, output byte_ready, load, we_ins, wr_addr);
    modport master (output byte_valid, byte_data, input  byte_ready, load, we_ins, wr_addr);
endinterface

// File: rtl/prog_loader.sv
// Assembles byte pairs into 16-bit words and writes NUM_WORDS of them to instruction memory.
// Optional trailing checksum byte enabled by `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int NUM_WORDS = 64,
    parameter bit HI_FIRST  = 1'b1
) (
    input  logic         clka,
    input  logic         reset,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         busy,
    output logic         done,
    output logic         csum_err
);
`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, BYTE0, BYTE1, WRITE, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, BYTE0, BYTE1, WRITE, DONE} state_t;
`endif

    localparam logic [5:0] LAST_ADDR = 6'(NUM_WORDS - 1);

    state_t      state_q, state_d;
    logic [15:0] load_q, load_d;
    logic [5:0]  addr_q, addr_d;
    logic        xfer;

    assign xfer = bus.byte_valid && bus.byte_ready;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d, sum_nxt;
    logic       csum_err_q, csum_err_d;

    assign sum_nxt  = sum_q + bus.byte_data;
    assign csum_err = csum_err_q;
`else
    assign csum_err = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        load_d         = load_q;
        addr_d         = addr_q;
        bus.byte_ready = 1'b0;
        bus.we_ins     = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        csum_err_d = csum_err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = BYTE0;
                    addr_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d      = '0;
                    csum_err_d = 1'b0;
`endif
                end
            end
            BYTE0: begin
                bus.byte_ready = 1'b1;
                if (xfer) begin
                    if (HI_FIRST) load_d[15:8] = bus.byte_data;
                    else          load_d[7:0]  = bus.byte_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d = sum_nxt;
`endif
                    state_d = BYTE1;
                end
            end
            BYTE1: begin
                bus.byte_ready = 1'b1;
                if (xfer) begin
                    if (HI_FIRST) load_d[7:0]  = bus.byte_data;
                    else          load_d[15:8] = bus.byte_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d = sum_nxt;
`endif
                    state_d = WRITE;
                end
            end
            WRITE: begin
                bus.we_ins = 1'b1;
                addr_d     = addr_q + 6'd1;
                if (addr_q == LAST_ADDR) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = BYTE0;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM: begin
                bus.byte_ready = 1'b1;
                if (xfer) begin
                    csum_err_d = (sum_nxt != 8'h00);
                    state_d    = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            load_q  <= '0;
            addr_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            csum_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            csum_err_q <= csum_err_d;
`endif
        end
    end

    // The processor is released only from a clean DONE; IDLE after reset keeps it held.
    assign cpu_reset   = (state_q != DONE) || csum_err;
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign bus.load    = load_q;
    assign bus.wr_addr = addr_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: three instances (2 words hi-first, 1 word lo-first,
// 64 words hi-first) share clock and reset; a monitor logs every write strobe.
module tb_prog_loader;
    logic clka = 1'b0;
    logic reset;
    always #5 clka = ~clka;

    logic [2:0]  st, vld;
    logic [7:0]  dat [3];
    logic [2:0]  rdy, we, cr, bz, dn, ce;
    logic [15:0] ld [3];
    logic [5:0]  ad [3];

    int n_pass = 0;
    int n_tot  = 0;

    prog_loader_if if0 ();
    prog_loader_if if1 ();
    prog_loader_if if2 ();

    assign if0.byte_valid = vld[0];
    assign if1.byte_valid = vld[1];
    assign if2.byte_valid = vld[2];
    assign if0.byte_data  = dat[0];
    assign if1.byte_data  = dat[1];
    assign if2.byte_data  = dat[2];
    assign rdy = {if2.byte_ready, if1.byte_ready, if0.byte_ready};
    assign we  = {if2.we_ins, if1.we_ins, if0.we_ins};
    assign ld[0] = if0.load;
    assign ld[1] = if1.load;
    assign ld[2] = if2.load;
    assign ad[0] = if0.wr_addr;
    assign ad[1] = if1.wr_addr;
    assign ad[2] = if2.wr_addr;

    prog_loader #(.NUM_WORDS(2), .HI_FIRST(1'b1)) u0 (
        .clka(clka), .reset(reset), .start(st[0]), .bus(if0),
        .cpu_reset(cr[0]), .busy(bz[0]), .done(dn[0]), .csum_err(ce[0]));
    prog_loader #(.NUM_WORDS(1), .HI_FIRST(1'b0)) u1 (
        .clka(clka), .reset(reset), .start(st[1]), .bus(if1),
        .cpu_reset(cr[1]), .busy(bz[1]), .done(dn[1]), .csum_err(ce[1]));
    prog_loader #(.NUM_WORDS(64), .HI_FIRST(1'b1)) u2 (
        .clka(clka), .reset(reset), .start(st[2]), .bus(if2),
        .cpu_reset(cr[2]), .busy(bz[2]), .done(dn[2]), .csum_err(ce[2]));

    // Write log, sampled mid-cycle while the strobe is stable.
    int          wcnt [3] = '{0, 0, 0};
    logic [5:0]  waddr [3][64];
    logic [15:0] wload [3][64];
    always @(negedge clka) begin
        for (int i = 0; i < 3; i++) begin
            if (we[i] === 1'b1) begin
                waddr[i][wcnt[i] % 64] = ad[i];
                wload[i][wcnt[i] % 64] = ld[i];
                wcnt[i] = wcnt[i] + 1;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input int i, input logic [7:0] b);
        int k;
        vld[i] = 1'b1;
        dat[i] = b;
        k = 0;
        while (rdy[i] !== 1'b1 && k < 20) begin
            @(negedge clka);
            k++;
        end
        if (k == 20) begin
            n_tot++;
            $display("FAIL send_byte[%0d]: byte_ready=%b never rose, required 1", i, rdy[i]);
        end
        @(negedge clka);
    endtask

    task automatic wait_done(input int i);
        int k;
        k = 0;
        while (dn[i] !== 1'b1 && k < 300) begin
            @(negedge clka);
            k++;
        end
        if (k == 300) begin
            n_tot++;
            $display("FAIL wait_done[%0d]: done=%b after timeout, required 1", i, dn[i]);
        end
        #1;
    endtask

    task automatic start_pulse(input int i);
        st[i] = 1'b1;
        @(negedge clka);
        st[i] = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        st[0] = 1'b1;
        repeat (2) @(negedge clka);
        st[0] = 1'b0;
        #1;
        n_tot++; if ({ld[0], ad[0]} !== 22'h0) $display("FAIL rst_bus: load/addr=%h required 0", {ld[0], ad[0]}); else n_pass++;
        n_tot++; if ({rdy[0], we[0], bz[0], dn[0], ce[0]} !== 5'b0) $display("FAIL rst_flags: rdy/we/busy/done/cerr=%b required 00000", {rdy[0], we[0], bz[0], dn[0], ce[0]}); else n_pass++;
        n_tot++; if (cr !== 3'b111) $display("FAIL rst_cpu_reset: %b required 111", cr); else n_pass++;
        @(negedge clka);
        reset = 1'b1;
        @(negedge clka);
        #1;
        n_tot++; if ({bz[0], cr[0]} !== 2'b01) $display("FAIL idle_after_rst: busy/cpu_reset=%b required 01", {bz[0], cr[0]}); else n_pass++;
    endtask

    task automatic test_hi_first;
        int base;
        base = wcnt[0];
        start_pulse(0);
        #1;
        n_tot++; if ({bz[0], cr[0], rdy[0]} !== 3'b111) $display("FAIL hi_session_start: busy/cpu_reset/rdy=%b required 111", {bz[0], cr[0], rdy[0]}); else n_pass++;
        send_byte(0, 8'h12);
        send_byte(0, 8'h34);
        send_byte(0, 8'hAB);  // presented during WRITE; must wait, not be swallowed
        send_byte(0, 8'hCD);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(0, 8'h42);
`endif
        vld[0] = 1'b0;
        wait_done(0);
        n_tot++; if (wcnt[0] - base !== 2) $display("FAIL hi_count: writes=%0d required 2", wcnt[0] - base); else n_pass++;
        n_tot++; if ({waddr[0][base % 64], wload[0][base % 64]} !== {6'd0, 16'h1234}) $display("FAIL hi_word0: addr/load=%0d/%h required 0/1234", waddr[0][base % 64], wload[0][base % 64]); else n_pass++;
        n_tot++; if ({waddr[0][(base + 1) % 64], wload[0][(base + 1) % 64]} !== {6'd1, 16'hABCD}) $display("FAIL hi_word1: addr/load=%0d/%h required 1/abcd", waddr[0][(base + 1) % 64], wload[0][(base + 1) % 64]); else n_pass++;
        n_tot++; if ({dn[0], cr[0], bz[0], ce[0]} !== 4'b1000) $display("FAIL hi_done: done/cpu_reset/busy/cerr=%b required 1000", {dn[0], cr[0], bz[0], ce[0]}); else n_pass++;
        repeat (2) @(negedge clka);
        #1;
        n_tot++; if ({ld[0], ad[0]} !== {16'hABCD, 6'd2}) $display("FAIL hi_done_hold: load/addr=%h/%0d required abcd/2", ld[0], ad[0]); else n_pass++;
    endtask

    task automatic test_lo_first;
        int base;
        base = wcnt[1];
        start_pulse(1);
        send_byte(1, 8'h34);
        send_byte(1, 8'h12);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(1, 8'hBA);
`endif
        vld[1] = 1'b0;
        wait_done(1);
        n_tot++; if (wcnt[1] - base !== 1) $display("FAIL lo_count: writes=%0d required 1", wcnt[1] - base); else n_pass++;
        n_tot++; if ({waddr[1][base % 64], wload[1][base % 64]} !== {6'd0, 16'h1234}) $display("FAIL lo_word0: addr/load=%0d/%h required 0/1234", waddr[1][base % 64], wload[1][base % 64]); else n_pass++;
        n_tot++; if ({dn[1], cr[1]} !== 2'b10) $display("FAIL lo_done: done/cpu_reset=%b required 10", {dn[1], cr[1]}); else n_pass++;
    endtask

    task automatic test_random_valid;
        int base, idx, k, bad;
        logic [7:0] sum;
        base = wcnt[2];
        sum  = 8'h00;
        start_pulse(2);
        idx = 0;
        k   = 0;
        while (idx < 128 && k < 5000) begin
            vld[2] = 1'($urandom_range(0, 1));
            dat[2] = (idx % 2 == 0) ? 8'(idx / 2) : (8'(idx / 2) ^ 8'hA5);
            if (vld[2] && rdy[2] === 1'b1) begin
                sum = sum + dat[2];
                idx++;
            end
            @(negedge clka);
            k++;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(2, 8'h00 - sum);
`endif
        vld[2] = 1'b0;
        wait_done(2);
        n_tot++; if (wcnt[2] - base !== 64) $display("FAIL rnd_count: writes=%0d required 64", wcnt[2] - base); else n_pass++;
        bad = -1;
        for (int w = 0; w < 64; w++) begin
            if (bad < 0 && {waddr[2][(base + w) % 64], wload[2][(base + w) % 64]} !== {6'(w), 8'(w), 8'(w) ^ 8'hA5})
                bad = w;
        end
        n_tot++; if (bad >= 0) $display("FAIL rnd_seq: word %0d addr/load=%0d/%h out of order or wrong", bad, waddr[2][(base + bad) % 64], wload[2][(base + bad) % 64]); else n_pass++;
        n_tot++; if ({ad[2], dn[2], cr[2]} !== {6'd0, 2'b10}) $display("FAIL rnd_done: addr/done/cpu_reset=%0d/%b/%b required 0/1/0", ad[2], dn[2], cr[2]); else n_pass++;
        n_tot++; if (ld[2] !== 16'h3F9A) $display("FAIL rnd_load_hold: load=%h required 3f9a", ld[2]); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int base;
        base = wcnt[2];
        start_pulse(2);
        for (int b = 0; b < 6; b++) send_byte(2, 8'(8'h40 + b));
        dat[2] = 8'h77;
        @(negedge clka);
        #2 reset = 1'b0;
        #1;
        n_tot++; if ({ld[2], ad[2]} !== 22'h0) $display("FAIL mid_rst_bus: load/addr=%h required 0", {ld[2], ad[2]}); else n_pass++;
        n_tot++; if ({rdy[2], we[2], bz[2], dn[2], cr[2]} !== 5'b00001) $display("FAIL mid_rst_flags: rdy/we/busy/done/cpu_reset=%b required 00001", {rdy[2], we[2], bz[2], dn[2], cr[2]}); else n_pass++;
        repeat (4) @(negedge clka);
        #1;
        n_tot++; if (wcnt[2] - base !== 3) $display("FAIL mid_rst_count: writes=%0d required 3", wcnt[2] - base); else n_pass++;
        reset = 1'b1;
        vld[2] = 1'b0;
        @(negedge clka);
        start_pulse(2);
        send_byte(2, 8'h5A);
        send_byte(2, 8'hC3);
        vld[2] = 1'b0;
        @(negedge clka);
        #1;
        n_tot++; if (wcnt[2] - base !== 4 || {waddr[2][(base + 3) % 64], wload[2][(base + 3) % 64]} !== {6'd0, 16'h5AC3}) $display("FAIL mid_restart: writes=%0d addr/load=%0d/%h required 4 0/5ac3", wcnt[2] - base, waddr[2][(base + 3) % 64], wload[2][(base + 3) % 64]); else n_pass++;
    endtask

    task automatic test_start_busy;
        int base;
        base = wcnt[0];
        start_pulse(0);
        send_byte(0, 8'h11);
        vld[0] = 1'b0;
        start_pulse(0);
        #1;
        n_tot++; if ({rdy[0], bz[0], ad[0]} !== {2'b11, 6'd0} || wcnt[0] != base) $display("FAIL start_in_byte1: rdy/busy/addr=%b/%b/%0d writes=%0d required 1/1/0 0", rdy[0], bz[0], ad[0], wcnt[0] - base); else n_pass++;
        send_byte(0, 8'h22);
        send_byte(0, 8'h33);
        send_byte(0, 8'h44);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(0, 8'h56);
`endif
        vld[0] = 1'b0;
        wait_done(0);
        n_tot++; if (wcnt[0] - base !== 2 || wload[0][base % 64] !== 16'h1122 || wload[0][(base + 1) % 64] !== 16'h3344) $display("FAIL start_busy_words: writes=%0d loads=%h/%h required 2 1122/3344", wcnt[0] - base, wload[0][base % 64], wload[0][(base + 1) % 64]); else n_pass++;
        @(negedge clka);
        st[0] = 1'b1;
        @(negedge clka);
        #1;
        n_tot++; if ({cr[0], bz[0], dn[0], ad[0]} !== {3'b110, 6'd0}) $display("FAIL restart_from_done: cpu_reset/busy/done/addr=%b/%b/%b/%0d required 1/1/0/0", cr[0], bz[0], dn[0], ad[0]); else n_pass++;
        @(negedge clka);
        st[0] = 1'b0;
        #1;
        n_tot++; if ({rdy[0], ad[0]} !== {1'b1, 6'd0}) $display("FAIL start_held_byte0: rdy/addr=%b/%0d required 1/0", rdy[0], ad[0]); else n_pass++;
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        send_byte(0, 8'h33);
        send_byte(0, 8'h44);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(0, 8'h56);
`endif
        vld[0] = 1'b0;
        wait_done(0);
        n_tot++; if (wcnt[0] - base !== 4) $display("FAIL restart_count: writes=%0d required 4", wcnt[0] - base); else n_pass++;
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        start_pulse(1);
        send_byte(1, 8'h01);
        send_byte(1, 8'h02);
        send_byte(1, 8'hFD);
        vld[1] = 1'b0;
        wait_done(1);
        n_tot++; if ({ce[1], cr[1]} !== 2'b00) $display("FAIL csum_good: cerr/cpu_reset=%b required 00", {ce[1], cr[1]}); else n_pass++;
        start_pulse(1);
        send_byte(1, 8'h01);
        send_byte(1, 8'h02);
        send_byte(1, 8'hFE);
        vld[1] = 1'b0;
        wait_done(1);
        n_tot++; if ({dn[1], ce[1], cr[1]} !== 3'b111) $display("FAIL csum_bad: done/cerr/cpu_reset=%b required 111", {dn[1], ce[1], cr[1]}); else n_pass++;
    endtask
`endif

    initial begin
        reset = 1'b0;
        st    = '0;
        vld   = '0;
        for (int i = 0; i < 3; i++) dat[i] = 8'h00;
        test_reset;
        test_hi_first;
        test_lo_first;
        test_random_valid;
        test_reset_mid;
        test_start_busy;
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum;
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
